alu_branch_req_issuer: RTL

// Drives branch-compare requests into the combinational ALU and returns each branch outcome to the requester.

---
 rtl/alu_branch_req_issuer.sv | 103 ++++++++++
 1 files changed

// File: rtl/alu_branch_req_issuer.sv
// alu_branch_req_issuer: registers branch-compare requests onto the ALU inputs and queues tagged outcomes.
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   flush_i                        drop the in-flight issue and all queued responses
//   req_valid_i/req_ready_o        request handshake; req_op_i, req_a_i, req_b_i, req_id_i
//   alu_valid_o, alu_op_o,
//   alu_operand_a_o/_b_o           registered request presented to the combinational ALU
//   alu_branch_res_i, alu_result_i ALU outputs for the presented request
//   rsp_valid_o/rsp_ready_i        response FIFO head handshake; rsp_id_o, rsp_branch_o, rsp_result_o
module alu_branch_req_issuer #(
    parameter int XLEN      = 64,
    parameter int OP_W      = 7,
    parameter int ID_W      = 3,
    parameter int RSP_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [OP_W-1:0] req_op_i,
    input  logic [XLEN-1:0] req_a_i,
    input  logic [XLEN-1:0] req_b_i,
    input  logic [ID_W-1:0] req_id_i,
    output logic            alu_valid_o,
    output logic [OP_W-1:0] alu_op_o,
    output logic [XLEN-1:0] alu_operand_a_o,
    output logic [XLEN-1:0] alu_operand_b_o,
    input  logic            alu_branch_res_i,
    input  logic [XLEN-1:0] alu_result_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [ID_W-1:0] rsp_id_o,
    output logic            rsp_branch_o,
    output logic [XLEN-1:0] rsp_result_o
);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(RSP_DEPTH);

    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   occ;
    logic [ID_W-1:0] issue_id;
    logic [ID_W-1:0] mem_id     [RSP_DEPTH];
    logic            mem_branch [RSP_DEPTH];
    logic [XLEN-1:0] mem_result [RSP_DEPTH];
    logic            accept, push, pop;

    // The request sitting on the ALU inputs already owns a FIFO slot, so it is counted as a credit.
    assign req_ready_o = rst_ni && !flush_i && (({1'b0, occ} + {{CW{1'b0}}, alu_valid_o}) < DEPTH_C);
    assign accept      = req_valid_i && req_ready_o;
    assign push        = alu_valid_o && !flush_i;
    assign rsp_valid_o = occ != '0;
    assign pop         = rsp_valid_o && rsp_ready_i && !flush_i;
    assign rsp_id_o     = mem_id[rd_ptr];
    assign rsp_branch_o = mem_branch[rd_ptr];
    assign rsp_result_o = mem_result[rd_ptr];

    // Operand registers only load on accept so the ALU inputs stay quiet while idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alu_valid_o     <= 1'b0;
            alu_op_o        <= '0;
            alu_operand_a_o <= '0;
            alu_operand_b_o <= '0;
            issue_id        <= '0;
        end else begin
            alu_valid_o <= accept;
            if (accept) begin
                alu_op_o        <= req_op_i;
                alu_operand_a_o <= req_a_i;
                alu_operand_b_o <= req_b_i;
                issue_id        <= req_id_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_id[i]     <= '0;
                mem_branch[i] <= 1'b0;
                mem_result[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem_id[wr_ptr]     <= issue_id;
                mem_branch[wr_ptr] <= alu_branch_res_i;
                mem_result[wr_ptr] <= alu_result_i;
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            occ <= occ + CW'(push) - CW'(pop);
        end
    end
endmodule
